uart_tx_engine: RTL

//  Transmit side of the UART core: drains bytes from the TX byte FIFO (active-low read,

---
 rtl/uart_tx_engine.sv | 105 ++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: drains the TX byte FIFO and serialises each byte as an async UART frame
module uart_tx_engine #(
   parameter logic [15:0] CLK_DIV   = 16'd347,
   parameter logic [1:0]  PARITY    = 2'd0,
   parameter logic [1:0]  STOP_BITS = 2'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_en_i,
   input  logic [7:0] fifo_data_i,
   input  logic       fifo_empty_i,
   output logic       n_re_o,
   output logic       tx_o,
   output logic       busy_o,
   output logic       done_o
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] START  = 3'd3;
   localparam logic [2:0] DATA   = 3'd4;
   localparam logic [2:0] PAR    = 3'd5;
   localparam logic [2:0] STOP   = 3'd6;
   localparam logic       PAR_EN = (PARITY == 2'd1) || (PARITY == 2'd2);
   localparam logic [2:0] LAST_STOP = (STOP_BITS == 2'd2) ? 3'd1 : 3'd0;
   logic [2:0]  state_q, state_d;
   logic [15:0] tmr_q, tmr_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic        par_q, par_d;
   logic        tx_q, tx_d;
   logic        n_re_q, n_re_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        tick;
   assign tick = tmr_q == CLK_DIV - 16'd1;
   always_comb begin
      state_d = state_q;
      tmr_d   = tick ? 16'd0 : tmr_q + 16'd1;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            tmr_d = 16'd0;
            cnt_d = 3'd0;
            if (tx_en_i && !fifo_empty_i) state_d = FETCH;
         end
         FETCH: begin
            tmr_d   = 16'd0;
            state_d = LOAD;
         end
         LOAD: begin
            tmr_d   = 16'd0;
            sh_d    = fifo_data_i;
            par_d   = (PARITY == 2'd1) ? ~^fifo_data_i : ^fifo_data_i;
            state_d = START;
         end
         START: if (tick) state_d = DATA;
         DATA: if (tick) begin
            cnt_d   = (cnt_q == 3'd7) ? 3'd0 : cnt_q + 3'd1;
            state_d = (cnt_q != 3'd7) ? DATA : PAR_EN ? PAR : STOP;
         end
         PAR: if (tick) state_d = STOP;
         STOP: if (tick) begin
            cnt_d   = (cnt_q == LAST_STOP) ? 3'd0 : cnt_q + 3'd1;
            state_d = (cnt_q == LAST_STOP) ? IDLE : STOP;
         end
         default: state_d = IDLE;
      endcase
      // outputs are registered, so they are derived from the state being entered
      tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[cnt_d] :
               (state_d == PAR) ? par_d : 1'b1;
      n_re_d = state_d != FETCH;
      busy_d = state_d != IDLE;
      done_d = (state_q == STOP) && (state_d == IDLE);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         tmr_q   <= 16'd0;
         cnt_q   <= 3'd0;
         sh_q    <= 8'd0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         n_re_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         n_re_q  <= n_re_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
   assign tx_o   = tx_q;
   assign n_re_o = n_re_q;
   assign busy_o = busy_q;
   assign done_o = done_q;
endmodule
